// File: rtl/testing_cpu_jtag_debug_pkg.sv
// Shared types for the JTAG debug action scheduler.
// Class codes, FSM states, slot layout and round-robin helpers.
package testing_cpu_jtag_debug_pkg;

  localparam logic [1:0] CLS_OCIMEM = 2'd0;
  localparam logic [1:0] CLS_BREAK  = 2'd1;
  localparam logic [1:0] CLS_TRACE  = 2'd2;

  localparam int SLOT_W = 38;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  typedef struct packed {
    logic              valid;
    logic [1:0]        op;
    logic [SLOT_W-1:0] data;
  } slot_t;

  function automatic logic [1:0] next_cls(
    input logic [1:0] c
  );
    return (c == CLS_TRACE) ? CLS_OCIMEM : c + 2'd1;
  endfunction

  // First occupied class at or after rr, wrapping.
  function automatic logic [1:0] rr_pick(
    input logic [2:0] pend,
    input logic [1:0] rr
  );
    logic [1:0] c;
    logic       hit;
    rr_pick = CLS_OCIMEM;
    hit     = 1'b0;
    c       = rr;
    for (int i = 0; i < 3; i++) begin
      if (!hit && pend[c]) begin
        rr_pick = c;
        hit     = 1'b1;
      end
      c = next_cls(c);
    end
  endfunction

endpackage

// File: rtl/testing_cpu_jtag_debug_action_slot.sv
// One pending slot: captures a class strobe with its jdo snapshot.
// Ports: strobe[N] in, jdo in, free in; valid/op/data out, drop out.
module testing_cpu_jtag_debug_action_slot #(
  parameter int N     = 2,
  parameter int JDO_W = 38
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N-1:0]     strobe,
  input  logic [JDO_W-1:0] jdo,
  input  logic             free,
  output logic             valid,
  output logic [1:0]       op,
  output logic [JDO_W-1:0] data,
  output logic             drop
);

  logic [1:0] low;
  logic       any;
  logic       multi;
  logic       take;

  always_comb begin
    low = 2'd0;
    for (int i = N - 1; i >= 0; i--) begin
      if (strobe[i]) low = 2'(i);
    end
  end

  assign any   = |strobe;
  assign multi = (strobe & (strobe - N'(1))) != '0;
  // A slot being freed this cycle can be refilled.
  assign take  = any && (!valid || free);
  assign drop  = any && (multi || (valid && !free));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid <= 1'b0;
      op    <= 2'd0;
      data  <= '0;
    end else if (take) begin
      valid <= 1'b1;
      op    <= low;
      data  <= jdo;
    end else if (free) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/testing_cpu_jtag_debug_action_sched.sv
// Latches debug action strobes and issues them round-robin, one at a time.
// Ports: strobes+jdo in; cmd_* valid/ready/done; busy/pending/overflow/timeout.
module testing_cpu_jtag_debug_action_sched
  import testing_cpu_jtag_debug_pkg::*;
#(
  parameter int TIMEOUT_W = 8,
  parameter int JDO_W     = 38
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [JDO_W-1:0] jdo,
  input  logic             take_action_ocimem_a,
  input  logic             take_action_ocimem_b,
  input  logic             take_action_break_a,
  input  logic             take_action_break_b,
  input  logic             take_action_break_c,
  input  logic             take_action_tracemem_a,
  input  logic             take_action_tracemem_b,
  input  logic             take_action_tracectrl,
  output logic             cmd_valid,
  output logic [1:0]       cmd_class,
  output logic [1:0]       cmd_op,
  output logic [JDO_W-1:0] cmd_data,
  input  logic             cmd_ready,
  input  logic             cmd_done,
  output logic             busy,
  output logic [2:0]       pending,
  output logic [2:0]       overflow,
  output logic             timeout,
  input  logic             clr_status
);

  // Expire on the edge where the counter would reach all-ones.
  localparam logic [TIMEOUT_W-1:0] LAST =
    {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  state_t                    state;
  state_t                    state_nx;
  logic [TIMEOUT_W-1:0]      cnt;
  logic [1:0]                cls;
  logic [1:0]                rr;
  logic [1:0]                sel;
  logic [2:0]                pend_v;
  logic [2:0][1:0]           op_s;
  logic [2:0][JDO_W-1:0]     data_s;
  logic [2:0]                drop;
  logic [2:0]                free;
  logic                      fin;
  logic                      expire;

  testing_cpu_jtag_debug_action_slot #(.N(2), .JDO_W(JDO_W)) u_oci (
    .clk     (clk),
    .reset_n (reset_n),
    .strobe  ({take_action_ocimem_b, take_action_ocimem_a}),
    .jdo     (jdo),
    .free    (free[CLS_OCIMEM]),
    .valid   (pend_v[CLS_OCIMEM]),
    .op      (op_s[CLS_OCIMEM]),
    .data    (data_s[CLS_OCIMEM]),
    .drop    (drop[CLS_OCIMEM])
  );

  testing_cpu_jtag_debug_action_slot #(.N(3), .JDO_W(JDO_W)) u_brk (
    .clk     (clk),
    .reset_n (reset_n),
    .strobe  ({take_action_break_c, take_action_break_b,
               take_action_break_a}),
    .jdo     (jdo),
    .free    (free[CLS_BREAK]),
    .valid   (pend_v[CLS_BREAK]),
    .op      (op_s[CLS_BREAK]),
    .data    (data_s[CLS_BREAK]),
    .drop    (drop[CLS_BREAK])
  );

  testing_cpu_jtag_debug_action_slot #(.N(3), .JDO_W(JDO_W)) u_trc (
    .clk     (clk),
    .reset_n (reset_n),
    .strobe  ({take_action_tracectrl, take_action_tracemem_b,
               take_action_tracemem_a}),
    .jdo     (jdo),
    .free    (free[CLS_TRACE]),
    .valid   (pend_v[CLS_TRACE]),
    .op      (op_s[CLS_TRACE]),
    .data    (data_s[CLS_TRACE]),
    .drop    (drop[CLS_TRACE])
  );

  assign sel = rr_pick(pend_v, rr);

  always_comb begin
    state_nx = state;
    fin      = 1'b0;
    expire   = 1'b0;
    unique case (state)
      IDLE: begin
        if (|pend_v) state_nx = ISSUE;
      end
      ISSUE: begin
        if (cmd_ready) begin
          if (cmd_done) fin = 1'b1;
          else          state_nx = WAIT;
        end else if (cnt == LAST) begin
          expire = 1'b1;
        end
      end
      WAIT: begin
        if (cmd_done)         fin    = 1'b1;
        else if (cnt == LAST) expire = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
    if (fin || expire) state_nx = IDLE;
    free = (fin || expire) ? (3'b001 << cls) : 3'b000;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      cls      <= CLS_OCIMEM;
      rr       <= CLS_OCIMEM;
      cmd_op   <= 2'd0;
      cmd_data <= '0;
      overflow <= 3'b000;
      timeout  <= 1'b0;
    end else begin
      state <= state_nx;
      if (state_nx != state) cnt <= '0;
      else if (state != IDLE) cnt <= cnt + TIMEOUT_W'(1);
      if (state == IDLE && |pend_v) begin
        cls      <= sel;
        cmd_op   <= op_s[sel];
        cmd_data <= data_s[sel];
      end
      if (fin || expire) rr <= next_cls(cls);
      // Set events win over a same-cycle clear.
      overflow <= (clr_status ? 3'b000 : overflow) | drop;
      timeout  <= (timeout && !clr_status) || expire;
    end
  end

  assign cmd_valid = (state == ISSUE);
  assign busy      = (state != IDLE);
  assign cmd_class = cls;
  assign pending   = pend_v;

endmodule

// File: tb/tb_testing_cpu_jtag_debug_action_sched.sv
// Directed and random checks of the action scheduler.
// Compares every cycle against a behavioural model of the rules.
module tb_testing_cpu_jtag_debug_action_sched;

  localparam int LIMIT = 15;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [37:0] jdo;
  logic        oci_a, oci_b, brk_a, brk_b, brk_c;
  logic        trc_a, trc_b, trc_c;
  logic        cmd_valid;
  logic [1:0]  cmd_class;
  logic [1:0]  cmd_op;
  logic [37:0] cmd_data;
  logic        cmd_ready, cmd_done;
  logic        busy;
  logic [2:0]  pending;
  logic [2:0]  overflow;
  logic        timeout;
  logic        clr;

  int ncmp = 0;
  int nfail = 0;

  int          m_state;
  int          m_cls, m_rr, m_age, m_cop;
  logic [37:0] m_cdata;
  bit          m_valid [3];
  int          m_op [3];
  logic [37:0] m_data [3];
  logic [2:0]  m_ovf;
  bit          m_to;

  testing_cpu_jtag_debug_action_sched #(
    .TIMEOUT_W(4),
    .JDO_W(38)
  ) dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .jdo                    (jdo),
    .take_action_ocimem_a   (oci_a),
    .take_action_ocimem_b   (oci_b),
    .take_action_break_a    (brk_a),
    .take_action_break_b    (brk_b),
    .take_action_break_c    (brk_c),
    .take_action_tracemem_a (trc_a),
    .take_action_tracemem_b (trc_b),
    .take_action_tracectrl  (trc_c),
    .cmd_valid              (cmd_valid),
    .cmd_class              (cmd_class),
    .cmd_op                 (cmd_op),
    .cmd_data               (cmd_data),
    .cmd_ready              (cmd_ready),
    .cmd_done               (cmd_done),
    .busy                   (busy),
    .pending                (pending),
    .overflow               (overflow),
    .timeout                (timeout),
    .clr_status             (clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: advances one clock using the current inputs.
  task automatic model_step();
    bit [2:0] sb [3];
    int nxt, freed, lo;
    bit fin, expd, found;
    if (!reset_n) begin
      m_state = 0; m_cls = 0; m_rr = 0; m_age = 0;
      m_cop = 0; m_cdata = '0; m_ovf = '0; m_to = 0;
      for (int c = 0; c < 3; c++) begin
        m_valid[c] = 0; m_op[c] = 0; m_data[c] = '0;
      end
      return;
    end
    sb[0] = {1'b0, oci_b, oci_a};
    sb[1] = {brk_c, brk_b, brk_a};
    sb[2] = {trc_c, trc_b, trc_a};
    fin = 0; expd = 0; nxt = m_state;
    if (m_state == 1) begin
      if (cmd_ready) begin
        if (cmd_done) fin = 1; else nxt = 2;
      end else if (m_age + 1 >= LIMIT) expd = 1;
    end else if (m_state == 2) begin
      if (cmd_done) fin = 1;
      else if (m_age + 1 >= LIMIT) expd = 1;
    end
    freed = (fin || expd) ? m_cls : -1;
    if (m_state == 0) begin
      found = 0;
      for (int k = 0; k < 3; k++) begin
        if (!found && m_valid[(m_rr + k) % 3]) begin
          found = 1;
          m_cls = (m_rr + k) % 3;
        end
      end
      if (found) begin
        m_cop = m_op[m_cls]; m_cdata = m_data[m_cls]; nxt = 1;
      end
    end
    if (fin || expd) nxt = 0;
    if (nxt != m_state) m_age = 0;
    else if (m_state != 0) m_age++;
    if (clr) begin m_ovf = '0; m_to = 0; end
    for (int c = 0; c < 3; c++) begin
      if (sb[c] != 0) begin
        lo = sb[c][0] ? 0 : (sb[c][1] ? 1 : 2);
        if (!m_valid[c] || c == freed) begin
          m_valid[c] = 1; m_op[c] = lo; m_data[c] = jdo;
          if ($countones(sb[c]) > 1) m_ovf[c] = 1;
        end else m_ovf[c] = 1;
      end else if (c == freed) m_valid[c] = 0;
    end
    if (expd) m_to = 1;
    if (fin || expd) m_rr = (freed + 1) % 3;
    m_state = nxt;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("m_valid", cmd_valid, m_state == 1);
    chk("m_busy", busy, m_state != 0);
    chk("m_pend", pending, {m_valid[2], m_valid[1], m_valid[0]});
    chk("m_ovf", overflow, m_ovf);
    chk("m_to", timeout, m_to);
    chk("m_class", cmd_class, m_cls);
    chk("m_op", cmd_op, m_cop);
    chk("m_data", cmd_data, m_cdata);
  endtask

  task automatic quiet();
    {oci_a, oci_b, brk_a, brk_b, brk_c, trc_a, trc_b, trc_c} = '0;
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 20 && !cmd_valid; i++) tick();
    chk(tag, cmd_valid, 1'b1);
  endtask

  logic [11:0] seq;
  int          n;

  initial begin
    reset_n = 0; jdo = '0; cmd_ready = 0; cmd_done = 0; clr = 0;
    quiet();
    tick(); tick();
    chk("rst_valid", cmd_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_pend", pending, 3'b000);
    chk("rst_flags", {overflow, timeout}, 4'b0000);
    chk("rst_data", cmd_data, 38'h0);
    reset_n = 1;

    // single strobe
    jdo = 38'h2A_1234_5678; oci_a = 1; cmd_ready = 1;
    tick(); quiet(); jdo = 38'h0F_0F0F_0F0F;
    chk("s1_pend", pending, 3'b001);
    chk("s1_early", cmd_valid, 1'b0);
    tick();
    chk("s1_valid", cmd_valid, 1'b1);
    chk("s1_cls_op", {cmd_class, cmd_op}, 4'b0000);
    chk("s1_data", cmd_data, 38'h2A_1234_5678);
    tick();
    chk("s1_wait", {busy, cmd_valid}, 2'b10);
    cmd_done = 1; tick(); cmd_done = 0;
    chk("s1_idle", busy, 1'b0);
    chk("s1_flags", {overflow, timeout}, 4'b0000);

    // round robin from a fresh pointer
    reset_n = 0; tick(); reset_n = 1;
    cmd_ready = 1; cmd_done = 1;
    for (int b = 0; b < 2; b++) begin
      brk_b = 1; trc_c = 1; oci_b = 1; jdo = 38'(b + 5);
      tick(); quiet();
      seq = '0;
      for (int i = 0; i < 10; i++) begin
        tick();
        if (cmd_valid) seq = {seq[7:0], cmd_class, cmd_op};
      end
      chk(b == 0 ? "rr_first" : "rr_second", seq, 12'h15A);
    end

    // overflow on an occupied slot
    cmd_ready = 0; cmd_done = 0;
    jdo = 38'h11_1111_1111; trc_a = 1; tick(); quiet();
    jdo = 38'h22_2222_2222; trc_b = 1; tick(); quiet();
    chk("ov_flag", overflow, 3'b100);
    wait_valid("ov_wait");
    chk("ov_op", cmd_op, 2'd0);
    chk("ov_data", cmd_data, 38'h11_1111_1111);
    cmd_ready = 1; tick(); cmd_ready = 0;
    cmd_done = 1; tick(); cmd_done = 0;
    clr = 1; tick(); clr = 0;
    chk("ov_clear", overflow, 3'b000);

    // refill a slot in its completion cycle
    cmd_ready = 1; jdo = 38'h33_0000_0003; brk_a = 1;
    tick(); quiet();
    wait_valid("rf_wait1");
    tick();
    cmd_done = 1; brk_c = 1; jdo = 38'h3C_CCCC_CCCC;
    tick(); cmd_done = 0; quiet();
    chk("rf_noovf", overflow, 3'b000);
    chk("rf_pend", pending[1], 1'b1);
    wait_valid("rf_wait2");
    chk("rf_cmd", {cmd_class, cmd_op}, 4'b0110);
    chk("rf_data", cmd_data, 38'h3C_CCCC_CCCC);
    tick(); cmd_done = 1; tick(); cmd_done = 0;

    // watchdog abort
    cmd_ready = 0; oci_a = 1; tick(); quiet();
    wait_valid("to_wait");
    n = 0;
    for (int i = 0; i < 30 && cmd_valid; i++) begin tick(); n++; end
    chk("to_len", n, 15);
    chk("to_flag", timeout, 1'b1);
    chk("to_pend", pending[0], 1'b0);
    cmd_ready = 1; oci_b = 1; jdo = 38'h0E_EEEE_EEEE; tick(); quiet();
    wait_valid("to_after");
    chk("to_after_cmd", {cmd_op, cmd_data}, {2'd1, 38'h0E_EEEE_EEEE});
    tick(); cmd_done = 1; tick(); cmd_done = 0;
    chk("to_after_idle", busy, 1'b0);

    // reset while waiting for done
    brk_b = 1; tick(); quiet();
    wait_valid("rw_wait");
    tick();
    chk("rw_inwait", {busy, cmd_valid}, 2'b10);
    reset_n = 0; tick(); reset_n = 1;
    chk("rw_zero", {cmd_valid, busy, pending, overflow, timeout,
                    cmd_class, cmd_op}, 13'h0);
    cmd_done = 1; tick(); cmd_done = 0;
    chk("rw_ignore", {busy, pending}, 4'b0000);
    trc_c = 1; jdo = 38'h1F_FFFF_0001; tick(); quiet();
    wait_valid("rw_new");
    chk("rw_new_cmd", {cmd_class, cmd_op, cmd_data},
        {2'd2, 2'd2, 38'h1F_FFFF_0001});
    tick(); cmd_done = 1; tick(); cmd_done = 0;

    // random traffic, varying resource responsiveness
    for (int seg = 0; seg < 6; seg++) begin
      for (int i = 0; i < 150; i++) begin
        {oci_a, oci_b, brk_a, brk_b, brk_c, trc_a, trc_b, trc_c} =
          8'($urandom & $urandom & $urandom);
        jdo = 38'({$urandom, $urandom});
        cmd_ready = ($urandom_range(0, 9) < (seg % 3) * 4 + 1);
        cmd_done = ($urandom_range(0, 9) < (seg % 3) * 3 + 1);
        clr = ($urandom_range(0, 19) == 0);
        reset_n = ($urandom_range(0, 199) != 0);
        tick();
      end
    end
    quiet(); reset_n = 1; clr = 0; cmd_ready = 0; cmd_done = 0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/testing_cpu_jtag_debug_action_sched.md
Name: testing_CPU_jtag_debug_action_sched

Overview:
- Sits in the clk domain between the JTAG debug module's system-clock action strobes (take_action_*, jdo) and the CPU's OCI resources: memory, break registers and trace.
- Latches each one-cycle action strobe with its jdo snapshot into a per-class pending slot.
- Arbitrates the three classes round-robin and issues one command at a time over a valid/ready/done handshake.
- Guarantees no strobe is silently lost; drops are flagged as overflow, and a stalled resource triggers a timeout abort.

Parameters:
- TIMEOUT_W, 8, width of watchdog counter; command aborted after 2**TIMEOUT_W-1 cycles without ready or done.
- JDO_W, 38, width of jdo snapshot and cmd_data.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- jdo  in  JDO_W  debug shift-register data, valid in the strobe cycle
- take_action_ocimem_a, take_action_ocimem_b  in  1 each  OCIMEM class strobes (op 0, 1)
- take_action_break_a, take_action_break_b, take_action_break_c  in  1 each  BREAK class strobes (op 0, 1, 2)
- take_action_tracemem_a, take_action_tracemem_b, take_action_tracectrl  in  1 each  TRACE class strobes (op 0, 1, 2)
- cmd_valid  out  1  command presented
- cmd_class  out  2  0=OCIMEM, 1=BREAK, 2=TRACE
- cmd_op  out  2  op within class
- cmd_data  out  JDO_W  jdo snapshot
- cmd_ready  in  1  resource accepts command
- cmd_done  in  1  resource finished accepted command
- busy  out  1  FSM not IDLE
- pending  out  3  slot-occupied bits [TRACE, BREAK, OCIMEM]
- overflow  out  3  sticky per-class drop flags
- timeout  out  1  sticky watchdog flag
- clr_status  in  1  clears overflow and timeout

Behaviour:
- Reset (reset_n low at a clk edge): all outputs 0; slots empty; FSM=IDLE; round-robin pointer=OCIMEM; counter=0. Reset mid-command abandons it with no done expected.
- Capture:
  - A strobe whose class slot is free, or freed this same cycle, loads {op, jdo} and sets pending the next cycle.
  - Strobe to an occupied slot that is not being freed: strobe dropped; overflow[class] set.
  - Two or more strobes of one class in one cycle: lowest op captured; overflow[class] set.
  - Strobes of different classes in the same cycle are all captured.
- FSM IDLE:
  - If any pending, pick the first pending class at or after the rr pointer (order OCIMEM, BREAK, TRACE, wrap).
  - Drive cmd_* from that slot next cycle; go to ISSUE; counter cleared.
  - A strobe landing in IDLE is issued at the earliest 2 cycles later (capture cycle, then select cycle).
- FSM ISSUE:
  - cmd_valid=1; cmd_class, cmd_op and cmd_data are stable until cmd_ready.
  - cmd_valid&cmd_ready: cmd_valid drops next cycle; go to WAIT; counter cleared.
  - If cmd_done is high in the same cycle as ready, the command completes immediately and the FSM returns to IDLE.
- FSM WAIT: cmd_done returns to IDLE. Ignore cmd_done in IDLE and ISSUE, except ready&done in ISSUE.
- Completion: slot freed; rr pointer = issued class+1 mod 3.
- Watchdog:
  - Counter increments each cycle in ISSUE and WAIT.
  - When it reaches all-ones: timeout set, slot freed, cmd_valid dropped, FSM to IDLE, rr advances as on completion.
- clr_status: clears flags next cycle. A set event in the same cycle wins over the clear.
- busy=1 in ISSUE and WAIT. pending reflects slot registers.
- Strict one outstanding command; no pipelining.

Decomposition:
- Package testing_CPU_jtag_debug_pkg:
  - class codes CLS_OCIMEM=0, CLS_BREAK=1, CLS_TRACE=2;
  - FSM state enum {IDLE, ISSUE, WAIT};
  - slot typedef {valid, op[1:0], data[JDO_W-1:0]}.
- One sub-module, testing_CPU_jtag_debug_action_slot: single-class capture/overflow/free logic, instantiated three times with class strobe counts 2/3/3.

Test Plan:
- Single strobe: take_action_ocimem_a with jdo=38'h2A_1234_5678, ready held 1, done 1 cycle after accept -> cmd_valid 2 cycles after strobe; class=0, op=0, data=38'h2A_1234_5678; busy falls after done; no flags.
- Round-robin: break_b, tracectrl and ocimem_b in the same cycle, immediate ready+done -> issue order OCIMEM(op1), BREAK(op1), TRACE(op2); next simultaneous batch starts at OCIMEM again.
- Overflow:
  - tracemem_a, then tracemem_b while ready=0 -> overflow=3'b100; the issued command is op0 with the first jdo.
  - clr_status -> overflow=0.
- Same-cycle free and refill: break_c strobe in the cycle cmd_done completes a BREAK command -> captured, no overflow, reissued.
- Timeout: TIMEOUT_W=4, ready never asserted -> cmd_valid high 15 cycles then low; timeout=1; pending bit cleared; a later command proceeds normally.
- Reset mid-WAIT: reset_n low 1 cycle -> all outputs 0; a subsequent cmd_done is ignored; a new strobe is processed normally.
